// File: rtl/wb_master_pkg.sv
// Shared state encoding and Wishbone cycle-type codes for the burst initiator.
package wb_master_pkg;
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Cycle type presented while beat idx (0-based) of a len-beat command is on the bus.
    function automatic logic [2:0] cti_for(input int idx, input int len);
        if (len == 1)
            return CTI_CLASSIC;
        else if (idx == len - 1)
            return CTI_EOB;
        else
            return CTI_INCR;
    endfunction
endpackage

// File: rtl/wb_master_wdog.sv
// Stall watchdog: counts strobe cycles without acknowledge; TIMEOUT of 0 never expires.
module wb_master_wdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (en)
            cnt_reg <= cnt_reg + CW'(1);
    end

    // Fires during the TIMEOUT-th consecutive stalled strobe cycle.
    assign expire = (TIMEOUT != 0) && en && (cnt_reg == CW'(LIMIT));
endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 initiator: one classic or incrementing-burst cycle per accepted command,
// with a one-entry write hold register and a stall watchdog.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw      = 16,
    parameter int APP_AW  = 26,
    parameter int MAX_BL  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [APP_AW-1:0]       req_addr,
    input  logic [$clog2(MAX_BL):0] req_len,
    input  logic [dw/8-1:0]         req_sel,
    input  logic                    wdat_valid,
    output logic                    wdat_ready,
    input  logic [dw-1:0]           wdat,
    output logic                    rdat_valid,
    output logic [dw-1:0]           rdat,
    output logic                    done,
    output logic                    err,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [APP_AW-1:0]       wb_addr_o,
    output logic [dw-1:0]           wb_dat_o,
    output logic [dw/8-1:0]         wb_sel_o,
    output logic [2:0]              wb_cti_o,
    input  logic                    wb_ack_i,
    input  logic [dw-1:0]           wb_dat_i
);
    localparam int LW = $clog2(MAX_BL) + 1;

    state_t            state_reg;
    logic [LW-1:0]     len_reg, beat_cnt_reg, fetch_cnt_reg;
    logic [APP_AW-1:0] addr_reg;
    logic [dw/8-1:0]   sel_reg;
    logic [dw-1:0]     hold_data_reg, rdat_reg;
    logic [2:0]        cti_reg;
    logic              we_reg, hold_full_reg, err_flag_reg;
    logic              req_ready_reg, cyc_reg, stb_reg;
    logic              rdat_valid_reg, done_reg, err_reg;

    logic accept, len_bad, beat_ack, last_beat, wdat_take, hold_full_next;
    logic wdog_expire;

    assign accept    = req_valid && req_ready_reg;
    assign len_bad   = (req_len == '0) || (req_len > LW'(MAX_BL));
    assign beat_ack  = stb_reg && wb_ack_i;
    assign last_beat = beat_ack && (beat_cnt_reg == len_reg - LW'(1));

    // The hold slot may refill in the same cycle its contents are acknowledged.
    assign wdat_ready = (state_reg == XFER) && we_reg && (fetch_cnt_reg != len_reg)
                        && (!hold_full_reg || beat_ack);
    assign wdat_take      = wdat_valid && wdat_ready;
    assign hold_full_next = (hold_full_reg && !beat_ack) || wdat_take;

    wb_master_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .clr    (beat_ack || (state_reg != XFER)),
        .en     (stb_reg && !wb_ack_i),
        .expire (wdog_expire)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            beat_cnt_reg   <= '0;
            fetch_cnt_reg  <= '0;
            addr_reg       <= '0;
            sel_reg        <= '0;
            hold_data_reg  <= '0;
            rdat_reg       <= '0;
            cti_reg        <= CTI_CLASSIC;
            we_reg         <= 1'b0;
            hold_full_reg  <= 1'b0;
            err_flag_reg   <= 1'b0;
            req_ready_reg  <= 1'b0;
            cyc_reg        <= 1'b0;
            stb_reg        <= 1'b0;
            rdat_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            rdat_valid_reg <= beat_ack && !we_reg;
            if (beat_ack && !we_reg)
                rdat_reg <= wb_dat_i;

            case (state_reg)
                IDLE: begin
                    req_ready_reg <= !accept;
                    if (accept) begin
                        addr_reg      <= req_addr;
                        len_reg       <= req_len;
                        we_reg        <= req_we;
                        sel_reg       <= req_sel;
                        beat_cnt_reg  <= '0;
                        fetch_cnt_reg <= '0;
                        hold_full_reg <= 1'b0;
                        err_flag_reg  <= len_bad;
                        if (len_bad) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= XFER;
                            cyc_reg   <= 1'b1;
                            stb_reg   <= !req_we;
                            cti_reg   <= cti_for(0, int'(req_len));
                        end
                    end
                end
                XFER: begin
                    if (wdat_take) begin
                        hold_data_reg <= wdat;
                        fetch_cnt_reg <= fetch_cnt_reg + LW'(1);
                    end
                    hold_full_reg <= hold_full_next;
                    if (beat_ack) begin
                        addr_reg     <= addr_reg + APP_AW'(dw / 8);
                        beat_cnt_reg <= beat_cnt_reg + LW'(1);
                    end
                    if (wdog_expire || last_beat) begin
                        state_reg    <= DONE;
                        cyc_reg      <= 1'b0;
                        stb_reg      <= 1'b0;
                        cti_reg      <= CTI_CLASSIC;
                        err_flag_reg <= wdog_expire;
                    end else begin
                        // Writes strobe only with data in hand; reads strobe continuously.
                        stb_reg <= we_reg ? hold_full_next : 1'b1;
                        if (beat_ack)
                            cti_reg <= cti_for(int'(beat_cnt_reg) + 1, int'(len_reg));
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    err_reg   <= err_flag_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign rdat_valid = rdat_valid_reg;
    assign rdat       = rdat_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign wb_cyc_o   = cyc_reg;
    assign wb_stb_o   = stb_reg;
    assign wb_we_o    = we_reg;
    assign wb_addr_o  = addr_reg;
    assign wb_dat_o   = hold_data_reg;
    assign wb_sel_o   = sel_reg;
    assign wb_cti_o   = cti_reg;
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: scoreboarded bus beats and read data against a simple slave.
`timescale 1ns/1ps
module tb_wb_burst_master;
    localparam int DW = 16, AW = 26, MAXBL = 8, TMO = 256;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic [1:0]    sel;
        logic [DW-1:0] dat;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid = 0, req_ready, req_we = 0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_len = '0;
    logic [1:0]    req_sel = '0;
    logic          wdat_valid = 0, wdat_ready;
    logic [DW-1:0] wdat = '0;
    logic          rdat_valid, done, err;
    logic [DW-1:0] rdat;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic [1:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          ack_en = 0;

    int checks = 0, errors = 0;
    beat_t         exp_beats[$];
    logic [DW-1:0] exp_rdat[$];
    logic [DW-1:0] wbuf [0:7];
    logic          ack_rd_d = 0;

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A0 ^ {a[25:16], 6'b0};
    endfunction

    assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en;
    assign wb_dat_i = slave_data(wb_addr_o);

    wb_burst_master #(.dw(DW), .APP_AW(AW), .MAX_BL(MAXBL), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_sel(req_sel),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every acknowledged beat and every read-data pulse is popped from the scoreboard.
    always @(negedge clk) begin
        beat_t obs;
        if (!rst_n) begin
            ack_rd_d <= 1'b0;
        end else begin
            if (rdat_valid || ack_rd_d)
                chk("rdat_latency", rdat_valid, ack_rd_d);
            if (rdat_valid) begin
                chk("rdat_pending", exp_rdat.size() != 0, 1);
                if (exp_rdat.size() != 0)
                    chk("rdat", rdat, exp_rdat.pop_front());
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                obs.we   = wb_we_o;
                obs.addr = wb_addr_o;
                obs.cti  = wb_cti_o;
                obs.sel  = wb_sel_o;
                obs.dat  = wb_we_o ? wb_dat_o : '0;
                chk("beat_pending", exp_beats.size() != 0, 1);
                if (exp_beats.size() != 0)
                    chk("beat", obs, exp_beats.pop_front());
            end
            ack_rd_d <= wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o;
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                         input logic [1:0] sel, input bit expect_beats);
        int n = 0;
        beat_t b;
        @(posedge clk); #1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = addr; req_len = len; req_sel = sel;
        if (expect_beats) begin
            for (int i = 0; i < int'(len); i++) begin
                b.we   = we;
                b.addr = addr + AW'(2 * i);
                b.cti  = (len == 1) ? 3'b000 : ((i == int'(len) - 1) ? 3'b111 : 3'b010);
                b.sel  = sel;
                b.dat  = we ? wbuf[i] : '0;
                exp_beats.push_back(b);
                if (!we) exp_rdat.push_back(slave_data(b.addr));
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic feed(input int n, input int gap_after, input int gap_len);
        int k;
        bit saw_low;
        for (int i = 0; i < n; i++) begin
            wdat_valid = 1; wdat = wbuf[i];
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!wdat_ready && k < 100);
            chk("wdat_ready_wait", wdat_ready, 1);
            @(posedge clk); #1;
            wdat_valid = 0;
            if (i == gap_after) begin
                saw_low = 0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("gap_cyc", wb_cyc_o, 1);
                    if (!wb_stb_o) saw_low = 1;
                    @(posedge clk); #1;
                end
                chk("gap_stb_low", saw_low, 1);
            end
        end
    endtask

    task automatic wait_done(input logic exp_err);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 1000);
        chk("done_seen", done, 1);
        chk("done_err", err, exp_err);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic illegal_len(input logic [3:0] len);
        issue(0, 26'h10, len, 2'b11, 0);
        @(negedge clk);
        chk("bad_len_cyc0", wb_cyc_o, 0);
        chk("bad_len_early", done, 0);
        @(negedge clk);
        chk("bad_len_done", done, 1);
        chk("bad_len_err", err, 1);
        chk("bad_len_cyc1", wb_cyc_o, 0);
        @(negedge clk);
        chk("bad_len_pulse", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int k, n;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", wb_addr_o, 0);
        @(posedge clk); #2 rst_n = 1;
        @(negedge clk);
        chk("ready_at_release", req_ready, 0);
        @(negedge clk);
        chk("ready_first_clock", req_ready, 1);

        // Single write
        ack_en = 1;
        wbuf[0] = 16'hA5A5;
        fork
            issue(1, 26'h100, 4'd1, 2'b11, 1);
            feed(1, -1, 0);
        join
        wait_done(0);

        // Read burst of 8
        issue(0, 26'h200, 4'd8, 2'b11, 1);
        wait_done(0);
        chk("rd8_beats_drained", exp_beats.size(), 0);
        chk("rd8_rdat_drained", exp_rdat.size(), 0);

        // Write burst of 4 with a data gap after beat 2
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        fork
            issue(1, 26'h300, 4'd4, 2'b01, 1);
            feed(4, 1, 3);
        join
        wait_done(0);
        chk("wr4_beats_drained", exp_beats.size(), 0);

        // Read with no acknowledge: watchdog abort
        ack_en = 0;
        issue(0, 26'h400, 4'd2, 2'b11, 0);
        k = 0; n = 0;
        while (k < 400) begin
            @(negedge clk);
            if (!wb_cyc_o) break;
            if (wb_stb_o) n++;
            k++;
        end
        chk("timeout_stb_cycles", n, TMO);
        wait_done(1);
        ack_en = 1;

        // Illegal lengths
        illegal_len(4'd0);
        illegal_len(4'd9);

        // Reset during beat 3 of an 8-beat read
        issue(0, 26'h200, 4'd8, 2'b11, 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wb_stb_o && wb_ack_i && wb_addr_o == 26'h204) && k < 50);
        chk("reach_beat3", wb_addr_o, 26'h204);
        @(posedge clk); #2 rst_n = 0;
        #1;
        chk("midrst_cyc", wb_cyc_o, 0);
        chk("midrst_stb", wb_stb_o, 0);
        chk("midrst_rdv", rdat_valid, 0);
        exp_beats.delete();
        exp_rdat.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        @(posedge clk); #2 rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            chk("postrst_no_done", done, 0);
        end
        issue(0, 26'h600, 4'd3, 2'b10, 1);
        wait_done(0);

        // Address wrap
        issue(0, 26'h3FFFFFE, 4'd2, 2'b11, 1);
        wait_done(0);

        repeat (3) @(negedge clk);
        chk("final_beats_drained", exp_beats.size(), 0);
        chk("final_rdat_drained", exp_rdat.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
